rr_arb8: RTL and testbench

Round-robin arbiter that shares one 8:1 select path among eight requesters. It registers a one-hot grant and drives the three mux select lines, so the granted requester's input is routed to the mux output. The grant is held for as long as the owner keeps its request high, and the next owner is chosen fairly by rotating priority. It sits directly in front of the team's 8-input mux as its only source of selects.

---
 rtl/rr_arb8_pkg.sv | 13 +
 rtl/rr_pick8.sv | 30 +++
 rtl/rr_arb8.sv | 113 +++++++++++
 tb/tb_rr_arb8.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rr_arb8_pkg.sv
// Shared definitions for the rr_arb8 round-robin arbiter.
//   ARB_N       : number of requesters sharing the 8:1 select path
//   arb_state_t : arbiter state encoding (ST_IDLE = 0, ST_BUSY = 1)
package rr_arb8_pkg;

    localparam int ARB_N = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker.
// Scans req in the order ptr, ptr+1, ..., ptr+7 (mod 8) and reports the
// first set bit.
//   req   [7:0] : request vector
//   ptr   [2:0] : index with highest priority
//   found       : at least one request bit is set
//   idx   [2:0] : index of the first set bit in search order (0 when !found)
module rr_pick8
    import rr_arb8_pkg::*;
(
    input  logic [ARB_N-1:0] req,
    input  logic [2:0]       ptr,
    output logic             found,
    output logic [2:0]       idx
);

    // Walk from the lowest priority (ptr+7) to the highest (ptr) so the
    // last hit written is the first one in search order.
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (req[3'(ptr + 3'(i))]) begin
                found = 1'b1;
                idx   = 3'(ptr + 3'(i));
            end
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter driving the select lines of an 8-input mux.
// A registered one-hot grant is held while the owner keeps its request high;
// after release the arbiter spends one idle cycle and then re-arbitrates with
// priority starting just past the previous owner.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, an owner that has held the grant for TIMEOUT cycles is
//   forced off if any other requester is pending (preempt pulses for one
//   cycle). When undefined, the owner holds indefinitely and preempt is 0.
//
// Ports:
//   clk              : rising-edge clock
//   reset            : synchronous, active-high reset
//   req     [7:0]    : request per requester (bit i = input i)
//   grant   [7:0]    : registered one-hot grant, zero when idle
//   valid            : a grant bit is set
//   sel0/sel1/sel2   : owner index, sel0 = MSB, sel2 = LSB; held while idle
//   preempt          : one-cycle pulse on forced release
module rr_arb8
    import rr_arb8_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ARB_N-1:0] req,
    output logic [ARB_N-1:0] grant,
    output logic             valid,
    output logic             sel0,
    output logic             sel1,
    output logic             sel2,
    output logic             preempt
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("rr_arb8: TIMEOUT must be in 2..255");
    end

    arb_state_t state;
    logic [2:0] ptr;
    logic [2:0] owner;
    logic       found;
    logic [2:0] idx;

`ifdef ARB_TIMEOUT_EN
    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt;
`endif

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ptr     <= 3'd0;
            owner   <= 3'd0;
            grant   <= '0;
            valid   <= 1'b0;
            sel0    <= 1'b0;
            sel1    <= 1'b0;
            sel2    <= 1'b0;
            preempt <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            preempt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state              <= ST_BUSY;
                        owner              <= idx;
                        grant              <= ARB_N'(1) << idx;
                        valid              <= 1'b1;
                        {sel0, sel1, sel2} <= idx;
`ifdef ARB_TIMEOUT_EN
                        cnt                <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    // Selects are left alone on release so the mux output
                    // stays on the last owner during the idle cycle.
                    if (!req[owner]) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        valid <= 1'b0;
                        ptr   <= owner + 3'd1;
`ifdef ARB_TIMEOUT_EN
                    end else if (cnt == LAST && (req & ~grant) != '0) begin
                        state   <= ST_IDLE;
                        grant   <= '0;
                        valid   <= 1'b0;
                        ptr     <= owner + 3'd1;
                        preempt <= 1'b1;
                    end else if (cnt != LAST) begin
                        // Saturates at LAST while nobody else is waiting.
                        cnt <= cnt + CW'(1);
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8. Each step drives req/reset for one cycle and
// queues the output word expected right after the next rising edge; a
// separate monitor pops and compares one word per cycle.
// Expected word layout: {preempt, valid, sel0, sel1, sel2, grant[7:0]}.
module tb_rr_arb8;

    localparam int W = 13;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic       valid;
    logic       sel0;
    logic       sel1;
    logic       sel2;
    logic       preempt;

    logic [W-1:0] exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;

    rr_arb8 #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .grant   (grant),
        .valid   (valid),
        .sel0    (sel0),
        .sel1    (sel1),
        .sel2    (sel2),
        .preempt (preempt)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ew(input logic [7:0] g, input logic [2:0] s,
                                        input logic p);
        ew = {p, (g != 8'h00), s, g};
    endfunction

    // driver: one cycle of stimulus plus the expected post-edge outputs
    task automatic step(input logic [7:0] r, input logic rs, input logic [W-1:0] e);
        @(posedge clk);
        #2;
        req   = r;
        reset = rs;
        exp_q.push_back(e);
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {preempt, valid, sel0, sel1, sel2, grant};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got p=%b v=%b sel=%b grant=%h want p=%b v=%b sel=%b grant=%h",
                             cyc, a[12], a[11], a[10:8], a[7:0], e[12], e[11], e[10:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        // reset, then idle
        step(8'h00, 1'b1, ew(8'h00, 3'd0, 1'b0));
        step(8'h00, 1'b1, ew(8'h00, 3'd0, 1'b0));
        for (int i = 0; i < 5; i++) step(8'h00, 1'b0, ew(8'h00, 3'd0, 1'b0));

        // a and h request: a wins (ptr 0), then h after one dead cycle
        step(8'h81, 1'b0, ew(8'h01, 3'd0, 1'b0));
        step(8'h81, 1'b0, ew(8'h01, 3'd0, 1'b0));
        step(8'h80, 1'b0, ew(8'h00, 3'd0, 1'b0));
        step(8'h80, 1'b0, ew(8'h80, 3'd7, 1'b0));
        step(8'h00, 1'b0, ew(8'h00, 3'd7, 1'b0));
        step(8'h00, 1'b0, ew(8'h00, 3'd7, 1'b0));

        // everyone requesting, each owner holds two cycles: 0..7 then wrap to 0
        for (int k = 0; k < 9; k++) begin
            logic [2:0] o;
            logic [7:0] g;
            o = 3'(k);
            g = 8'h01 << o;
            step(8'hFF, 1'b0, ew(g, o, 1'b0));
            step(8'hFF, 1'b0, ew(g, o, 1'b0));
            step(8'hFF & ~g, 1'b0, ew(8'h00, o, 1'b0));
        end
        step(8'h00, 1'b0, ew(8'h00, 3'd0, 1'b0));

        // owner 3 interrupted by reset, regranted one edge after release
        step(8'h08, 1'b0, ew(8'h08, 3'd3, 1'b0));
        step(8'h08, 1'b0, ew(8'h08, 3'd3, 1'b0));
        step(8'h08, 1'b1, ew(8'h00, 3'd0, 1'b0));
        step(8'h08, 1'b0, ew(8'h08, 3'd3, 1'b0));
        step(8'h00, 1'b0, ew(8'h00, 3'd3, 1'b0));
        step(8'h00, 1'b0, ew(8'h00, 3'd3, 1'b0));

`ifdef ARB_TIMEOUT_EN
        // ptr is 4: b wins, is forced off after 4 cycles, then c
        for (int i = 0; i < 4; i++) step(8'h06, 1'b0, ew(8'h02, 3'd1, 1'b0));
        step(8'h06, 1'b0, ew(8'h00, 3'd1, 1'b1));
        step(8'h06, 1'b0, ew(8'h04, 3'd2, 1'b0));
        step(8'h00, 1'b0, ew(8'h00, 3'd2, 1'b0));
        // lone requester f keeps the grant, no preempt
        for (int i = 0; i < 20; i++) step(8'h20, 1'b0, ew(8'h20, 3'd5, 1'b0));
        step(8'h00, 1'b0, ew(8'h00, 3'd5, 1'b0));
`else
        // ptr is 4: b wins and keeps the grant despite c waiting
        for (int i = 0; i < 12; i++) step(8'h06, 1'b0, ew(8'h02, 3'd1, 1'b0));
        step(8'h00, 1'b0, ew(8'h00, 3'd1, 1'b0));
        step(8'h04, 1'b0, ew(8'h04, 3'd2, 1'b0));
        step(8'h00, 1'b0, ew(8'h00, 3'd2, 1'b0));
`endif

        // drain: bounded wait for the monitor to consume everything
        repeat (3) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
